bitcol_mac_sequencer: RTL and testbench
=======================================

Name: bitcol_mac_sequencer

Overview:
Sequences one bit-column MAC datapath through a complete dot-product job: pipeline flush, accumulator clear, a bit-serial column sweep per weight tile, pipeline drain, then result hand-off. It sits between the job scheduler (in_valid/in_ready), the per-column control/operand buffer (ctrl_valid/ctrl_ready), and the MAC's clk/reset/en/column_idx/is_msb pins. The MAC has a 2-stage accumulate pipeline whose internal stage registers are not cleared by its reset, so this block flushes them explicitly.

Parameters:
NUM_COLS, 8, weight bit-columns per tile; column_idx runs 0..NUM_COLS-1, LSB first
COL_W, $clog2(NUM_COLS), width of column_idx
TILE_W, 8, width of the tile-count field
DRAIN_CYCLES, 2, MAC pipeline depth to flush/drain

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_valid  in  1  new job offered
in_ready  out  1  block idle, job accepted when in_valid&in_ready
job_tiles  in  TILE_W  tiles to accumulate; 0 is treated as 1
ctrl_valid  in  1  operand/control word for the current column available
ctrl_ready  out  1  current column consumed this cycle
mac_en  out  1  MAC enable
mac_clr  out  1  drives MAC reset (zeroes the accumulator)
mac_op_gate  out  1  forces MAC column operands to zero
column_idx  out  COL_W  MAC column index
is_msb  out  1  current column is the sign column
col_first  out  1  first column of the job
out_valid  out  1  MAC result is final
out_ready  in  1  consumer takes the result

Behaviour:
- Reset: state IDLE. in_ready=1. All other outputs 0, counters 0. A reset mid-job aborts the job without producing a result.
- All outputs are registered, except in_ready and ctrl_ready, which are decoded from state and inputs.
- States:
  - IDLE: in_ready=1. On accept, latch tiles = (job_tiles==0 ? 1 : job_tiles) and go to FLUSH.
  - FLUSH: DRAIN_CYCLES cycles with mac_en=1 and mac_op_gate=1, which pushes zeros into the MAC stage registers. Then go to CLEAR.
  - CLEAR: 1 cycle with mac_clr=1 and mac_en=0. Then go to RUN with col=0, tile=0.
  - RUN: ctrl_ready=ctrl_valid.
    - On ctrl_valid: mac_en=1, mac_op_gate=0, column_idx=col, is_msb=(col==NUM_COLS-1), col_first=(col==0 && tile==0).
    - On !ctrl_valid (stall): mac_en=0, counters hold, column_idx/is_msb hold.
    - When col reaches NUM_COLS-1 it wraps to 0 and tile increments.
    - The last column of the last tile is consumed → go to DRAIN.
  - DRAIN: DRAIN_CYCLES cycles with mac_en=1 and mac_op_gate=1. Then go to DONE.
  - DONE: out_valid=1, mac_en=0. Held until out_ready, then go to IDLE. in_ready rises on the cycle after the handshake.
- Unstalled job latency, accept edge to out_valid: DRAIN_CYCLES+1+tiles*NUM_COLS+DRAIN_CYCLES cycles.
- Exclusivity: mac_clr and mac_en are never both 1. ctrl_ready=0 outside RUN.
- in_valid while busy is ignored (in_ready=0), with no loss of the current job.
- out_ready asserted before out_valid has no effect.
- A tile count of all ones is legal; the tile counter must not overflow before the compare.

Optional Feature:
SEQ_PERF_CNT_EN:
- Defined: adds output stall_cnt [31:0], counting RUN cycles with ctrl_valid=0. It clears on job accept, saturates at 2^32-1, and is stable while out_valid=1.
- Undefined: the port and counter are absent. Sequencing is identical.

Test Plan:
- Reset, then one job (job_tiles=1) with ctrl_valid tied high → FLUSH mac_en=1/gate=1 for 2 cycles, mac_clr 1 cycle, column_idx 0..7 with is_msb only at 7, 2 drain cycles, out_valid exactly 13 cycles after the accept.
- job_tiles=3 → column_idx sequence 0..7 repeated 3 times, is_msb pulses 3 times, col_first only once, out_valid after 29 cycles; job_tiles=0 behaves like 1.
- ctrl_valid low for 4 cycles at column 5 → mac_en=0 and column_idx held at 5 through the stall, out_valid delayed by exactly 4 cycles, stall_cnt=4 (SEQ_PERF_CNT_EN).
- out_ready held low 10 cycles in DONE → out_valid stays 1 and in_ready stays 0; a new in_valid during DONE is not accepted until after the handshake.
- reset asserted in RUN at column 3 → next cycle IDLE, mac_en=0, out_valid never asserted; the following job runs a full FLUSH/CLEAR and completes normally.
- Assertion check over all tests → mac_clr&mac_en never 1, ctrl_ready=0 outside RUN, in_ready=0 whenever state≠IDLE.

Source files
------------

// File: rtl/bitcol_mac_sequencer.sv
`default_nettype none
// ============================================================================
// bitcol_mac_sequencer -- runs one bit-column MAC through flush, clear,
// per-tile LSB-first column sweep, drain and result hand-off.
// Optional build macro: SEQ_PERF_CNT_EN (adds the stall_cnt output).
// Revision: 1.0
// ============================================================================
module bitcol_mac_sequencer #(
  parameter int NUM_COLS     = 8,
  parameter int COL_W        = $clog2(NUM_COLS),
  parameter int TILE_W       = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TILE_W-1:0] job_tiles,
  input  logic              ctrl_valid,
  output logic              ctrl_ready,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              mac_op_gate,
  output logic [COL_W-1:0]  column_idx,
  output logic              is_msb,
  output logic              col_first,
  output logic              out_valid,
  input  logic              out_ready
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_CLEAR = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [TILE_W-1:0]   tile_q, tile_d;
  logic [TILE_W-1:0]   tiles_q, tiles_d;
  logic                mac_en_q, mac_en_d;
  logic                mac_clr_q, mac_clr_d;
  logic                gate_q, gate_d;
  logic [COL_W-1:0]    column_idx_q, column_idx_d;
  logic                is_msb_q, is_msb_d;
  logic                col_first_q, col_first_d;
  logic                out_valid_q, out_valid_d;

  assign in_ready    = (state_q == S_IDLE);
  assign ctrl_ready  = (state_q == S_RUN) && ctrl_valid;
  assign mac_en      = mac_en_q;
  assign mac_clr     = mac_clr_q;
  assign mac_op_gate = gate_q;
  assign column_idx  = column_idx_q;
  assign is_msb      = is_msb_q;
  assign col_first   = col_first_q;
  assign out_valid   = out_valid_q;

  // Outputs are computed from the transition being taken and registered, so
  // each registered value lines up with the state it belongs to.  A consumed
  // column is presented the cycle after its handshake, which means the first
  // drain cycle carries the last column into the MAC.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    col_d        = col_q;
    tile_d       = tile_q;
    tiles_d      = tiles_q;
    mac_en_d     = 1'b0;
    mac_clr_d    = 1'b0;
    gate_d       = 1'b0;
    column_idx_d = column_idx_q;
    is_msb_d     = 1'b0;
    col_first_d  = 1'b0;
    out_valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          tiles_d  = (job_tiles == '0) ? TILE_W'(1) : job_tiles;
          cnt_d    = '0;
          state_d  = S_FLUSH;
          mac_en_d = 1'b1;
          gate_d   = 1'b1;
        end
      end
      S_FLUSH: begin
        if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          cnt_d     = '0;
          state_d   = S_CLEAR;
          mac_clr_d = 1'b1;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          mac_en_d = 1'b1;
          gate_d   = 1'b1;
        end
      end
      S_CLEAR: begin
        col_d   = '0;
        tile_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (ctrl_valid) begin
          mac_en_d     = 1'b1;
          column_idx_d = col_q;
          is_msb_d     = (col_q == COL_W'(NUM_COLS - 1));
          col_first_d  = (col_q == '0) && (tile_q == '0);
          if (col_q == COL_W'(NUM_COLS - 1)) begin
            col_d = '0;
            // Compare against tiles-1 so a full-scale tile count never wraps.
            if (tile_q == tiles_q - 1'b1) begin
              cnt_d   = '0;
              state_d = S_DRAIN;
            end else begin
              tile_d = tile_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          is_msb_d = is_msb_q;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          cnt_d       = '0;
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          mac_en_d = 1'b1;
          gate_d   = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      col_q        <= '0;
      tile_q       <= '0;
      tiles_q      <= '0;
      mac_en_q     <= 1'b0;
      mac_clr_q    <= 1'b0;
      gate_q       <= 1'b0;
      column_idx_q <= '0;
      is_msb_q     <= 1'b0;
      col_first_q  <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      col_q        <= col_d;
      tile_q       <= tile_d;
      tiles_q      <= tiles_d;
      mac_en_q     <= mac_en_d;
      mac_clr_q    <= mac_clr_d;
      gate_q       <= gate_d;
      column_idx_q <= column_idx_d;
      is_msb_q     <= is_msb_d;
      col_first_q  <= col_first_d;
      out_valid_q  <= out_valid_d;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if ((state_q == S_IDLE) && in_valid) begin
      stall_cnt_q <= '0;
    end else if ((state_q == S_RUN) && !ctrl_valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bitcol_mac_sequencer.sv
`default_nettype none
// ============================================================================
// tb_bitcol_mac_sequencer -- randomized scoreboard bench for the sequencer.
// Revision: 1.0
// ============================================================================
module tb_bitcol_mac_sequencer;

  localparam int NUM_COLS = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       ctrl_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] job_tiles = 8'd0;
  logic       in_ready, ctrl_ready, mac_en, mac_clr, mac_op_gate;
  logic       is_msb, col_first, out_valid;
  logic [2:0] column_idx;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  bitcol_mac_sequencer #(
    .NUM_COLS(8), .COL_W(3), .TILE_W(8), .DRAIN_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .job_tiles(job_tiles),
    .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_op_gate(mac_op_gate),
    .column_idx(column_idx), .is_msb(is_msb), .col_first(col_first),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef SEQ_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Expected job: effective tile count, cycle (after the accept edge) in which
  // the last column is consumed, result latency, and stall cycles in RUN.
  typedef struct {
    int tiles;
    int kl;
    int lat;
    int stalls;
  } exp_t;

  exp_t expq[$];
  exp_t cur;
  bit   cvq[$];
  int   n_checks = 0;
  int   n_pass = 0;
  bit   active = 1'b0;
  bit   post_rst = 1'b0;
  int   k = 0;
  int   n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    chk("clr_en_exclusive", {63'd0, mac_clr & mac_en}, 64'd0);
    if (reset) begin
      active   = 1'b0;
      post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        post_rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mac_en", mac_en, 0);
        chk("rst_mac_clr", mac_clr, 0);
        chk("rst_gate", mac_op_gate, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_column_idx", column_idx, 0);
        chk("rst_is_msb", is_msb, 0);
        chk("rst_col_first", col_first, 0);
`ifdef SEQ_PERF_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif
      end
      if (active) begin
        chk("busy_in_ready", in_ready, 0);
        chk("ctrl_ready", ctrl_ready, (k >= 3 && k <= cur.kl) ? ctrl_valid : 1'b0);
        chk("mac_clr", mac_clr, (k == 2));
        if (k < 2) chk("flush_en_gate", {mac_en, mac_op_gate}, 2'b11);
        if (k == cur.lat - 1) chk("drain_en_gate", {mac_en, mac_op_gate}, 2'b11);
        chk("out_valid", out_valid, (k >= cur.lat));
        if (k >= cur.lat) chk("done_mac_en", mac_en, 0);
        if (mac_en && !mac_op_gate && k >= 3) begin
          if (n >= cur.tiles * NUM_COLS) begin
            chk("extra_column", n, cur.tiles * NUM_COLS);
          end else begin
            chk("column_idx", column_idx, n % NUM_COLS);
            chk("is_msb", is_msb, (n % NUM_COLS) == NUM_COLS - 1);
            chk("col_first", col_first, (n == 0));
          end
          n++;
        end else if (k >= 3 && n > 0 && n < cur.tiles * NUM_COLS) begin
          chk("stall_mac_en", mac_en, 0);
          chk("stall_column_hold", column_idx, (n - 1) % NUM_COLS);
          chk("stall_msb_hold", is_msb, ((n - 1) % NUM_COLS) == NUM_COLS - 1);
        end
`ifdef SEQ_PERF_CNT_EN
        if (k < 3) chk("stall_cnt_cleared", stall_cnt, 0);
        if (k >= cur.lat) chk("stall_cnt", stall_cnt, cur.stalls);
`endif
        if (k >= cur.lat && out_valid && out_ready) begin
          chk("columns_total", n, cur.tiles * NUM_COLS);
          active = 1'b0;
        end else if (k > cur.lat + 100) begin
          chk("job_timeout", 0, 1);
          active = 1'b0;
        end
        k++;
      end else begin
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_mac_en", mac_en, 0);
        chk("idle_ctrl_ready", ctrl_ready, 0);
        if (in_valid && in_ready) begin
          if (expq.size() == 0) begin
            chk("unexpected_accept", 1, 0);
          end else begin
            cur    = expq.pop_front();
            active = 1'b1;
            k      = 0;
            n      = 0;
          end
        end
      end
    end
  end

  // Builds the ctrl_valid pattern (indexed by cycle after the accept edge)
  // and derives the expected job timing from it. RUN starts three cycles
  // after accept (two flush cycles, one clear cycle).
  task automatic build_job(input int tiles, input int mode, output exp_t e);
    int cols = ((tiles == 0) ? 1 : tiles) * NUM_COLS;
    int consumed = 0;
    int c = 3;
    bit b;
    cvq.delete();
    for (int i = 0; i < 3; i++) cvq.push_back(1'($urandom % 2));
    while (consumed < cols) begin
      case (mode)
        0:       b = 1'b1;
        1:       b = !(c >= 9 && c <= 12);
        default: b = ($urandom_range(0, 9) < 7);
      endcase
      cvq.push_back(b);
      if (b) consumed++;
      if (consumed == cols) e.kl = c;
      c++;
    end
    e.tiles  = (tiles == 0) ? 1 : tiles;
    e.lat    = e.kl + 3;
    e.stalls = (e.kl - 3 + 1) - cols;
  endtask

  task automatic offer(input int tiles, output bit ok);
    int t = 0;
    in_valid  = 1'b1;
    job_tiles = 8'(tiles);
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 3000);
    ok = in_ready;
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic run_job(input int tiles, input int mode, input int hold,
                         input bit early, input int next_tiles);
    exp_t e;
    bit ok;
    build_job(tiles, mode, e);
    expq.push_back(e);
    offer(tiles, ok);
    if (!ok) return;
    for (int j = 0; j <= e.lat + hold; j++) begin
      ctrl_valid = (j < cvq.size()) ? cvq[j] : 1'($urandom % 2);
      out_ready  = (j < e.lat) ? 1'($urandom % 2) : (j >= e.lat + hold);
      if (early && j >= e.lat) begin
        in_valid  = 1'b1;
        job_tiles = 8'(next_tiles);
      end else if (j < e.lat) begin
        in_valid  = 1'($urandom % 2);
        job_tiles = 8'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    out_ready  = 1'b0;
    ctrl_valid = 1'($urandom % 2);
    if (!early) in_valid = 1'b0;
  endtask

  // Job aborted by reset while column 3 is being consumed.
  task automatic run_abort(input int tiles);
    exp_t e;
    bit ok;
    build_job(tiles, 0, e);
    expq.push_back(e);
    offer(tiles, ok);
    if (!ok) return;
    for (int j = 0; j <= 6; j++) begin
      ctrl_valid = 1'b1;
      reset      = (j == 6);
      @(posedge clk);
      #1;
    end
    reset      = 1'b0;
    ctrl_valid = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nt, t, hold;
    bit early;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    run_job(1, 0, 0, 1'b0, 0);
    run_job(3, 0, 0, 1'b0, 0);
    run_job(0, 0, 0, 1'b0, 0);
    run_job(1, 1, 0, 1'b0, 0);
    run_job(2, 0, 10, 1'b1, 1);
    run_job(1, 0, 0, 1'b0, 0);
    run_abort(2);
    run_job(1, 0, 0, 1'b0, 0);
    run_job(255, 0, 2, 1'b0, 0);
    nt = $urandom_range(0, 5);
    for (int i = 0; i < 25; i++) begin
      t     = nt;
      nt    = $urandom_range(0, 5);
      hold  = $urandom_range(0, 4);
      early = (i < 24) ? 1'($urandom % 2) : 1'b0;
      run_job(t, 2, hold, early, nt);
    end
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("queue_empty", expq.size(), 0);
    chk("monitor_idle", active, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
